// File: rtl/mano_pkg.sv
// mano_pkg: shared definitions for the Mano-style memory master.
//   AW / DW      : address and data widths
//   AND .. RR    : 3-bit opcode field values (IR[14:12])
//   state_t      : controller state encoding
//   is_mem_state : true for states that own a memory request
package mano_pkg;

    localparam int AW = 12;
    localparam int DW = 16;

    localparam logic [2:0] AND = 3'd0;
    localparam logic [2:0] ADD = 3'd1;
    localparam logic [2:0] LDA = 3'd2;
    localparam logic [2:0] STA = 3'd3;
    localparam logic [2:0] BUN = 3'd4;
    localparam logic [2:0] BSA = 3'd5;
    localparam logic [2:0] ISZ = 3'd6;
    localparam logic [2:0] RR  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_INDIR,
        ST_OPRD,
        ST_WRBK,
        ST_ISZWR,
        ST_RRWAIT
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_INDIR) || (s == ST_OPRD) ||
               (s == ST_WRBK)  || (s == ST_ISZWR);
    endfunction

endpackage

// File: rtl/mano_req_port.sv
// mano_req_port: single-outstanding memory request port with ack timeout.
//   clk, rst_n        : clock, asynchronous active-low reset
//   issue/issue_wr    : launch a read (issue_wr=0) or write (issue_wr=1) when idle
//   issue_addr/wdata  : address and write data captured at launch
//   mem_ack           : memory completion strobe
//   mem_rd/mem_wr/... : registered request towards memory, held until ack
//   active            : a request is on the bus
//   done              : ack seen this cycle (request drops at this edge)
//   timeout           : WAIT_MAX cycles elapsed without ack (request drops)
module mano_req_port
    import mano_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_addr,
    input  logic [DW-1:0] issue_wdata,
    input  logic          mem_ack,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_ar,
    output logic [DW-1:0] mem_wdata,
    output logic          active,
    output logic          done,
    output logic          timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] ar_q, ar_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign active  = rd_q | wr_q;
    assign done    = active & mem_ack;
    // cnt_q counts completed cycles of the current request; the request is
    // visible for exactly WAIT_MAX cycles before being abandoned.
    assign timeout = active & ~mem_ack & (cnt_q == CW'(WAIT_MAX - 1));

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        ar_d    = ar_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (done || timeout) begin
            rd_d  = 1'b0;
            wr_d  = 1'b0;
            cnt_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + CW'(1);
        end else if (issue) begin
            rd_d    = ~issue_wr;
            wr_d    = issue_wr;
            ar_d    = issue_addr;
            wdata_d = issue_wdata;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ar_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ar_q    <= ar_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_ar    = ar_q;
    assign mem_wdata = wdata_q;

endmodule

// File: rtl/mano_mem_master.sv
// mano_mem_master: instruction fetch / operand access controller.
//   CLK, RST_N           : clock, asynchronous active-low reset
//   START                : leave IDLE and fetch at PC
//   MEM_*                : memory request/ack interface (via mano_req_port)
//   AC_IN                : accumulator value stored by STA
//   OP_VALID/OP_DATA     : operand pulse for AND/ADD/LDA, OPCODE = IR[14:12]
//   RR_VALID, RR_DONE/SKIP/HALT : hand-off of opcode-7 instructions
//   IR, PC, BUSY, ERR    : architectural registers and status
module mano_mem_master
    import mano_pkg::*;
#(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          WAIT_MAX = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic [AW-1:0] MEM_AR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic          MEM_ACK,
    input  logic [DW-1:0] AC_IN,
    output logic          OP_VALID,
    output logic [DW-1:0] OP_DATA,
    output logic [2:0]    OPCODE,
    output logic          RR_VALID,
    input  logic          RR_DONE,
    input  logic          RR_SKIP,
    input  logic          RR_HALT,
    output logic [DW-1:0] IR,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic          ERR
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [DW-1:0] data_q, data_d;        // ISZ incremented value
    logic          err_q, err_d;
    logic          op_valid_q, op_valid_d;
    logic [DW-1:0] op_data_q, op_data_d;
    logic          rr_valid_q, rr_valid_d;

    logic [2:0]    opcode;
    logic          do_disp;
    logic [AW-1:0] disp_ea;

    logic          req_issue, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          port_active, port_done, port_timeout;

    assign opcode = ir_q[14:12];

    mano_req_port #(.WAIT_MAX(WAIT_MAX)) u_port (
        .clk         (CLK),
        .rst_n       (RST_N),
        .issue       (req_issue),
        .issue_wr    (req_wr),
        .issue_addr  (req_addr),
        .issue_wdata (req_wdata),
        .mem_ack     (MEM_ACK),
        .mem_rd      (MEM_RD),
        .mem_wr      (MEM_WR),
        .mem_ar      (MEM_AR),
        .mem_wdata   (MEM_WDATA),
        .active      (port_active),
        .done        (port_done),
        .timeout     (port_timeout)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ea_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_data_q  <= '0;
            rr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ea_q       <= ea_d;
            data_q     <= data_d;
            err_q      <= err_d;
            op_valid_q <= op_valid_d;
            op_data_q  <= op_data_d;
            rr_valid_q <= rr_valid_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ea_d       = ea_q;
        data_d     = data_q;
        err_d      = err_q;
        op_valid_d = 1'b0;
        op_data_d  = op_data_q;
        rr_valid_d = 1'b0;
        do_disp    = 1'b0;
        disp_ea    = ea_q;

        case (state_q)
            ST_IDLE: if (START) state_d = ST_FETCH;
            ST_FETCH: if (port_done) begin
                ir_d    = MEM_RDATA;
                pc_d    = pc_q + 12'd1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ea_d = ir_q[11:0];
                if (ir_q[15] && opcode != RR) begin
                    state_d = ST_INDIR;
                end else begin
                    do_disp = 1'b1;
                    disp_ea = ir_q[11:0];
                end
            end
            ST_INDIR: if (port_done) begin
                ea_d    = MEM_RDATA[AW-1:0];
                do_disp = 1'b1;
                disp_ea = MEM_RDATA[AW-1:0];
            end
            ST_OPRD: if (port_done) begin
                if (opcode == ISZ) begin
                    data_d  = MEM_RDATA + 16'd1;
                    state_d = ST_ISZWR;
                end else begin
                    op_valid_d = 1'b1;
                    op_data_d  = MEM_RDATA;
                    state_d    = ST_FETCH;
                end
            end
            ST_WRBK: if (port_done) begin
                if (opcode == BSA) pc_d = ea_q + 12'd1;
                state_d = ST_FETCH;
            end
            ST_ISZWR: if (port_done) begin
                if (data_q == 16'h0000) pc_d = pc_q + 12'd1;
                state_d = ST_FETCH;
            end
            ST_RRWAIT: if (RR_DONE) begin
                // Skip is applied even when halting.
                if (RR_SKIP) pc_d = pc_q + 12'd1;
                state_d = RR_HALT ? ST_IDLE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_disp) begin
            case (opcode)
                AND, ADD, LDA, ISZ: state_d = ST_OPRD;
                STA, BSA:           state_d = ST_WRBK;
                BUN: begin
                    pc_d    = disp_ea;
                    state_d = ST_FETCH;
                end
                default: begin
                    rr_valid_d = 1'b1;
                    state_d    = ST_RRWAIT;
                end
            endcase
        end

        if (port_timeout) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // Memory request generation. A request launches on the first cycle of a
    // memory state; since the port drops the previous request at the ack
    // edge, this always leaves one idle bus cycle between requests.
    always_comb begin
        req_issue = is_mem_state(state_q) && !port_active;
        req_wr    = 1'b0;
        req_addr  = ea_q;
        req_wdata = '0;
        case (state_q)
            ST_FETCH: req_addr = pc_q;
            ST_WRBK: begin
                req_wr    = 1'b1;
                req_wdata = (opcode == BSA) ? {{(DW-AW){1'b0}}, pc_q} : AC_IN;
            end
            ST_ISZWR: begin
                req_wr    = 1'b1;
                req_wdata = data_q;
            end
            default: ;
        endcase
    end

    assign OP_VALID = op_valid_q;
    assign OP_DATA  = op_data_q;
    assign OPCODE   = opcode;
    assign RR_VALID = rr_valid_q;
    assign IR       = ir_q;
    assign PC       = pc_q;
    assign BUSY     = (state_q != ST_IDLE);
    assign ERR      = err_q;

endmodule

// File: tb/tb_mano_mem_master.sv
module tb_mano_mem_master;

    localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_OPV = 2'd2, K_RR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [11:0] addr;
        logic [15:0] data;
        logic [2:0]  op;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RST_N, START;
    logic        MEM_RD, MEM_WR, MEM_ACK;
    logic [11:0] MEM_AR, PC;
    logic [15:0] MEM_WDATA, MEM_RDATA, AC_IN, OP_DATA, IR;
    logic        OP_VALID, RR_VALID, RR_DONE, RR_SKIP, RR_HALT, BUSY, ERR;
    logic [2:0]  OPCODE;

    mano_mem_master #(.RESET_PC(12'h000), .WAIT_MAX(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_AR(MEM_AR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .AC_IN(AC_IN),
        .OP_VALID(OP_VALID), .OP_DATA(OP_DATA), .OPCODE(OPCODE),
        .RR_VALID(RR_VALID), .RR_DONE(RR_DONE), .RR_SKIP(RR_SKIP), .RR_HALT(RR_HALT),
        .IR(IR), .PC(PC), .BUSY(BUSY), .ERR(ERR)
    );

    initial forever #5 CLK = ~CLK;

    // Stimulus-side state (written only by the initial block).
    logic [15:0] mem [0:4095];
    logic        no_ack, rr_skip_cfg, rr_halt_cfg;
    txn_t        exp_q[$];
    int          n_cmp = 0, n_err = 0, obs_rd = 0;

    // Responder-side state (written only by the responder block).
    txn_t        obs_arr [0:255];
    int          obs_wr = 0, proto_err = 0, age = 0, rr_cnt = 0;
    logic [11:0] ar_seen;
    logic [15:0] wd_seen;

    function automatic txn_t mk(input logic [1:0] k, input logic [11:0] a,
                                input logic [15:0] d, input logic [2:0] op);
        txn_t t;
        t.kind = k; t.addr = a; t.data = d; t.op = op;
        return t;
    endfunction

    // Memory (ack in the 2nd request cycle) and datapath (done 3 cycles
    // after RR_VALID) responders; every completed access is logged.
    always @(negedge CLK) begin
        if (!RST_N) begin
            MEM_ACK = 1'b0; age = 0; rr_cnt = 0;
            RR_DONE = 1'b0; RR_SKIP = 1'b0; RR_HALT = 1'b0;
        end else begin
            if (MEM_RD && MEM_WR) proto_err++;
            if (MEM_ACK) begin
                MEM_ACK = 1'b0;
                age = 0;
                if (MEM_RD || MEM_WR) proto_err++;
            end else if ((MEM_RD || MEM_WR) && !no_ack) begin
                if (age == 0) begin
                    age = 1; ar_seen = MEM_AR; wd_seen = MEM_WDATA;
                end else begin
                    if (MEM_AR !== ar_seen || MEM_WDATA !== wd_seen) proto_err++;
                    MEM_ACK = 1'b1;
                    if (MEM_RD) begin
                        MEM_RDATA = mem[MEM_AR];
                        obs_arr[obs_wr % 256] = mk(K_RD, MEM_AR, mem[MEM_AR], 3'd0);
                    end else begin
                        obs_arr[obs_wr % 256] = mk(K_WR, MEM_AR, MEM_WDATA, 3'd0);
                    end
                    obs_wr++;
                end
            end
            if (OP_VALID) begin
                obs_arr[obs_wr % 256] = mk(K_OPV, PC, OP_DATA, OPCODE);
                obs_wr++;
            end
            if (RR_VALID) begin
                obs_arr[obs_wr % 256] = mk(K_RR, PC, IR, OPCODE);
                obs_wr++;
                rr_cnt = 3;
            end else if (RR_DONE) begin
                RR_DONE = 1'b0; RR_SKIP = 1'b0; RR_HALT = 1'b0;
            end else if (rr_cnt != 0) begin
                rr_cnt--;
                if (rr_cnt == 0) begin
                    RR_DONE = 1'b1; RR_SKIP = rr_skip_cfg; RR_HALT = rr_halt_cfg;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_txn(input logic [1:0] k, input logic [11:0] a,
                              input logic [15:0] d, input logic [2:0] op);
        exp_q.push_back(mk(k, a, d, op));
    endtask

    task automatic drain();
        txn_t o, e;
        while (obs_rd != obs_wr) begin
            o = obs_arr[obs_rd % 256];
            obs_rd++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_extra: observed %h required none", o);
            end else begin
                e = exp_q.pop_front();
                $display("txn kind=%0d addr=%03h data=%04h op=%0d", o.kind, o.addr, o.data, o.op);
                chk("sb_txn", 64'(o), 64'(e));
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_prog(input int budget);
        logic fin;
        fin = 1'b0;
        pulse_start();
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            drain();
            if (!BUSY) begin
                fin = 1'b1;
                break;
            end
        end
        chk("run_to_idle", 64'(fin), 64'd1);
        drain();
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);
        chk("protocol", 64'(proto_err), 64'd0);
    endtask

    initial begin
        int cnt;
        RST_N = 1'b1; START = 1'b0; AC_IN = 16'h0000;
        no_ack = 1'b0; rr_skip_cfg = 1'b0; rr_halt_cfg = 1'b1;
        clear_mem();

        // Reset values, checked while RST_N is low with no clock edge involved.
        #2 RST_N = 1'b0;
        #1;
        chk("rst_mem_rd", 64'(MEM_RD), 64'd0);
        chk("rst_mem_wr", 64'(MEM_WR), 64'd0);
        chk("rst_op_valid", 64'(OP_VALID), 64'd0);
        chk("rst_rr_valid", 64'(RR_VALID), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_ir", 64'(IR), 64'd0);
        chk("rst_mem_ar", 64'(MEM_AR), 64'd0);
        chk("rst_mem_wdata", 64'(MEM_WDATA), 64'd0);
        chk("rst_op_data", 64'(OP_DATA), 64'd0);
        chk("rst_opcode", 64'(OPCODE), 64'd0);
        chk("rst_pc", 64'(PC), 64'h000);

        // LDA direct
        clear_mem(); mem[0] = 16'h2005; mem[5] = 16'h1234; mem[1] = 16'h7001;
        expect_txn(K_RD, 12'h000, 16'h2005, 3'd0);
        expect_txn(K_RD, 12'h005, 16'h1234, 3'd0);
        expect_txn(K_OPV, 12'h001, 16'h1234, 3'd2);
        expect_txn(K_RD, 12'h001, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h002, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);
        chk("lda_pc", 64'(PC), 64'h002);

        // LDA indirect
        clear_mem(); mem[0] = 16'hA007; mem[7] = 16'h0010; mem[16'h010] = 16'hBEEF; mem[1] = 16'h7001;
        expect_txn(K_RD, 12'h000, 16'hA007, 3'd0);
        expect_txn(K_RD, 12'h007, 16'h0010, 3'd0);
        expect_txn(K_RD, 12'h010, 16'hBEEF, 3'd0);
        expect_txn(K_OPV, 12'h001, 16'hBEEF, 3'd2);
        expect_txn(K_RD, 12'h001, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h002, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);

        // ISZ wrapping to zero skips the next instruction
        clear_mem(); mem[0] = 16'h6003; mem[3] = 16'hFFFF; mem[2] = 16'h7001;
        expect_txn(K_RD, 12'h000, 16'h6003, 3'd0);
        expect_txn(K_RD, 12'h003, 16'hFFFF, 3'd0);
        expect_txn(K_WR, 12'h003, 16'h0000, 3'd0);
        expect_txn(K_RD, 12'h002, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h003, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);

        // ISZ without wrap: no skip
        clear_mem(); mem[0] = 16'h6003; mem[3] = 16'h0005; mem[1] = 16'h7001;
        expect_txn(K_RD, 12'h000, 16'h6003, 3'd0);
        expect_txn(K_RD, 12'h003, 16'h0005, 3'd0);
        expect_txn(K_WR, 12'h003, 16'h0006, 3'd0);
        expect_txn(K_RD, 12'h001, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h002, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);

        // BSA
        clear_mem(); mem[0] = 16'h5020; mem[12'h021] = 16'h7001;
        expect_txn(K_WR, 12'h020, 16'h0001, 3'd0);
        exp_q.push_front(mk(K_RD, 12'h000, 16'h5020, 3'd0));
        expect_txn(K_RD, 12'h021, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h022, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);
        chk("bsa_pc", 64'(PC), 64'h022);

        // STA writes AC_IN
        clear_mem(); mem[0] = 16'h3040; mem[1] = 16'h7001; AC_IN = 16'hCAFE;
        expect_txn(K_RD, 12'h000, 16'h3040, 3'd0);
        expect_txn(K_WR, 12'h040, 16'hCAFE, 3'd0);
        expect_txn(K_RD, 12'h001, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h002, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);

        // RR halt
        clear_mem(); mem[0] = 16'h7001;
        expect_txn(K_RD, 12'h000, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h001, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);
        chk("halt_busy", 64'(BUSY), 64'd0);
        chk("halt_pc", 64'(PC), 64'h001);

        // PC wrap: BUN to FFF, fetch there, PC becomes 000
        clear_mem(); mem[0] = 16'h4FFF; mem[12'hFFF] = 16'h7000;
        expect_txn(K_RD, 12'h000, 16'h4FFF, 3'd0);
        expect_txn(K_RD, 12'hFFF, 16'h7000, 3'd0);
        expect_txn(K_RR, 12'h000, 16'h7000, 3'd7);
        reset_dut(); run_prog(200);
        chk("wrap_pc", 64'(PC), 64'h000);

        // RR skip and halt together: skip applied, then idle
        clear_mem(); mem[0] = 16'h7001; rr_skip_cfg = 1'b1;
        expect_txn(K_RD, 12'h000, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h001, 16'h7001, 3'd7);
        reset_dut(); run_prog(200);
        chk("skiphalt_pc", 64'(PC), 64'h002);
        chk("skiphalt_busy", 64'(BUSY), 64'd0);
        rr_skip_cfg = 1'b0;

        // Ack timeout
        clear_mem(); no_ack = 1'b1;
        reset_dut(); pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (MEM_RD) break;
            @(negedge CLK);
        end
        chk("to_req_seen", 64'(MEM_RD), 64'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (ERR) break;
            if (MEM_RD) cnt++;
            @(negedge CLK);
        end
        $display("timeout after %0d request cycles", cnt);
        chk("to_cycles", 64'(cnt), 64'd16);
        chk("to_err", 64'(ERR), 64'd1);
        chk("to_busy", 64'(BUSY), 64'd0);
        chk("to_rd_drop", 64'(MEM_RD), 64'd0);
        repeat (3) @(negedge CLK);
        chk("to_err_sticky", 64'(ERR), 64'd1);

        // Reset in the middle of a read, then restart from RESET_PC
        reset_dut();
        chk("err_cleared", 64'(ERR), 64'd0);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (MEM_RD) break;
            @(negedge CLK);
        end
        chk("abort_req_seen", 64'(MEM_RD), 64'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("abort_rd_async", 64'(MEM_RD), 64'd0);
        chk("abort_busy_async", 64'(BUSY), 64'd0);
        chk("abort_pc_async", 64'(PC), 64'h000);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        no_ack = 1'b0;
        mem[0] = 16'h7001;
        @(negedge CLK);
        expect_txn(K_RD, 12'h000, 16'h7001, 3'd0);
        expect_txn(K_RR, 12'h001, 16'h7001, 3'd7);
        run_prog(200);
        chk("restart_pc", 64'(PC), 64'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mano_mem_master.md
MANO_MEM_MASTER -- requirements
Module: mano_mem_master

Interface
REQ-001 Parameter RESET_PC, default 12'h000, PC value loaded on reset.
REQ-002 Parameter WAIT_MAX, default 16, maximum number of cycles to wait for MEM_ACK before an error is flagged.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  one-cycle pulse; leaves IDLE and begins fetching at the current PC.
REQ-006 MEM_RD  out  1  read request to MEMORY.
REQ-007 MEM_WR  out  1  write request to MEMORY.
REQ-008 MEM_AR  out  12  memory address.
REQ-009 MEM_WDATA  out  16  write data.
REQ-010 MEM_RDATA  in  16  read data; valid in the cycle MEM_ACK is high.
REQ-011 MEM_ACK  in  1  memory completion strobe.
REQ-012 AC_IN  in  16  datapath accumulator value, used by STA.
REQ-013 OP_VALID  out  1  one-cycle pulse; OP_DATA and OPCODE are valid.
REQ-014 OP_DATA  out  16  operand for AND, ADD and LDA.
REQ-015 OPCODE  out  3  IR[14:12] of the current instruction.
REQ-016 RR_VALID  out  1  one-cycle pulse; register-reference/IO instruction (opcode 7) handed to the datapath.
REQ-017 RR_DONE, RR_SKIP, RR_HALT  in  1 each  datapath completion, skip-next-instruction and halt flags.
REQ-018 IR  out  16, PC  out  12  architectural registers.
REQ-019 BUSY  out  1, ERR  out  1  BUSY is high whenever state is not IDLE; ERR is a sticky ack-timeout flag.

Function
REQ-020 States are IDLE, FETCH, DECODE, INDIR, OPRD, WRBK, ISZWR, RRWAIT.
- IDLE → FETCH on START.
- FETCH: read at PC; on ack, IR←RDATA, PC←PC+1, → DECODE.
REQ-021 DECODE: EA←IR[11:0].
- If IR[15]=1 and opcode≠7 → INDIR.
- Otherwise dispatch per REQ-022.
- INDIR: read at EA; on ack, EA←RDATA[11:0], then dispatch.
REQ-022 Dispatch by opcode:
- 0/1/2 → OPRD: read at EA; on ack, OP_VALID pulses the next cycle with OP_DATA=RDATA; → FETCH.
- 3 → WRBK: write AC_IN to EA.
- 4 → PC←EA; → FETCH; no memory access.
- 5 → WRBK: write PC to EA, then PC←EA+1.
- 6 → OPRD, then ISZWR: write RDATA+1; if the result is 16'h0000, PC←PC+1.
- 7 → RR_VALID pulse → RRWAIT.
REQ-023 RRWAIT on RR_DONE:
- RR_SKIP → PC←PC+1.
- RR_HALT → IDLE; otherwise → FETCH.
- If RR_SKIP and RR_HALT are both set, apply the skip first, then go to IDLE.
REQ-024 Handshake:
- MEM_RD or MEM_WR is asserted with MEM_AR/MEM_WDATA stable until the rising edge at which MEM_ACK=1.
- The request drops the next cycle.
- At most one request is outstanding; MEM_RD and MEM_WR are never high together.
- MEM_ACK while idle is ignored.
REQ-025 Latency: minimum 2 cycles per memory access (request cycle + ack cycle); there is no back-to-back request without one deasserted cycle.
REQ-026 Arithmetic: PC and EA increment modulo 2^12 (12'hFFF+1=12'h000); ISZ increments modulo 2^16.
REQ-027 Ack timeout: no ack within WAIT_MAX cycles → ERR←1, request dropped, → IDLE; ERR is cleared only by reset.
REQ-028 START outside IDLE is ignored.

Reset
REQ-029 While RST_N=0, outputs are forced immediately, without waiting for a clock edge:
- MEM_RD=MEM_WR=0, OP_VALID=RR_VALID=0, BUSY=ERR=0.
- IR=0, MEM_AR=0, MEM_WDATA=0, OP_DATA=0, OPCODE=0.
- PC=RESET_PC, state=IDLE.
REQ-030 Reset mid-access aborts the access; no retry after release; the memory content is undefined for an aborted write.
REQ-031 The first START after RST_N rises fetches from RESET_PC.

Structure
REQ-032 Shared package mano_pkg holds:
- opcode constants AND..RR (3'd0..3'd7);
- the state enum;
- width constants AW=12 and DW=16.
REQ-033 The request/ack/timeout logic lives in one sub-module, mano_req_port; the FSM lives in mano_mem_master.

Verification
REQ-034 Memory model: ack on the 2nd cycle.
- Setup: [0]=16'h2005 (LDA 5), [5]=16'h1234.
- START → fetch then operand read; OP_VALID with OP_DATA=16'h1234, OPCODE=2; PC=1.
REQ-035 Indirect path.
- Setup: [0]=16'hA007, [7]=16'h0010, [10]=16'hBEEF.
- START → three reads at 0, 7, 16'h010; OP_DATA=16'hBEEF.
REQ-036 ISZ wrap.
- Setup: [0]=16'h6003, [3]=16'hFFFF.
- START → write 16'h0000 to address 3; PC=2 before the next fetch.
REQ-037 BSA: [0]=16'h5020 → write 16'h0001 to address 16'h020; PC=16'h021.
REQ-038 RR halt.
- Setup: [0]=16'h7001; datapath responds RR_DONE+RR_HALT after 3 cycles.
- Required: IDLE, BUSY=0, PC=1.
- Second test: PC=12'hFFF fetch → PC wraps to 0.
REQ-039 Fault cases.
- Memory never acks → ERR=1 after 16 cycles, then IDLE.
- RST_N low during MEM_RD → MEM_RD=0 without waiting for a clock edge.
